// File: rtl/ofifo_collector.sv
// Output-side collector for the MAC array: one FWFT FIFO per column absorbs the
// column-to-column valid skew and presents fully aligned psum rows to the reader.
module ofifo_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   WeightOrOutput,
  input  logic [col-1:0]         valid,
  input  logic [psum_bw*col-1:0] out_s,
  input  logic [psum_bw*col-1:0] OS_out,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [psum_bw-1:0] mem_q [col][depth];
  logic [psum_bw-1:0] lane_in [col];

  logic [AW:0]      wr_ptr_q [col];
  logic [AW:0]      wr_ptr_d [col];
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      rd_ptr_d;
  logic             overflow_q;
  logic             overflow_d;

  logic [col-1:0]   full;
  logic [col-1:0]   empty;
  logic [col-1:0]   wr_en;
  logic             pop;

  // All columns pop together, so a single read pointer serves every column.
  always_comb begin
    for (int c = 0; c < col; c++) begin
      empty[c]   = (wr_ptr_q[c] == rd_ptr_q);
      full[c]    = (wr_ptr_q[c][AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[c][AW-1:0] == rd_ptr_q[AW-1:0]);
      lane_in[c] = WeightOrOutput ? OS_out[c*psum_bw +: psum_bw]
                                  : out_s[c*psum_bw +: psum_bw];
    end
  end

  assign wr_en    = valid & ~full;
  assign o_valid  = ~|empty;
  assign o_full   = |full;
  assign o_ready  = ~o_full;
  assign pop      = rd & o_valid;
  assign overflow = overflow_q;

  always_comb begin
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = overflow_q | (|(valid & full));
    for (int c = 0; c < col; c++) begin
      wr_ptr_d[c] = wr_en[c] ? wr_ptr_q[c] + PTR_ONE : wr_ptr_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int c = 0; c < col; c++) begin
        wr_ptr_q[c] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      for (int c = 0; c < col; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
      end
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (wr_en[c]) begin
        mem_q[c][wr_ptr_q[c][AW-1:0]] <= lane_in[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < col; c++) begin
      out[c*psum_bw +: psum_bw] = o_valid ? mem_q[c][rd_ptr_q[AW-1:0]] : '0;
    end
  end

endmodule
